// File: rtl/apb_master_bridge.sv
// Bridges the core's single-transfer data bus onto an APB3 master with a
// four-way peripheral decode and a bounded ACCESS phase.
module apb_master_bridge #(
  parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transfer,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        ready,
  output logic        busErr,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  pready_vec;
  logic [3:0]  psel_vec;
  logic [31:0] prdata_arr [4];
  logic        addr_hit;
  logic        apb_active;

  assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};
  assign prdata_arr[0] = PRDATA0;
  assign prdata_arr[1] = PRDATA1;
  assign prdata_arr[2] = PRDATA2;
  assign prdata_arr[3] = PRDATA3;

  // Window match plus slot 0..3 only; anything above slot 3 is unmapped.
  assign addr_hit   = (busAddr[31:16] == ADDR_BASE[31:16]) && (busAddr[15:14] == 2'b00);
  assign apb_active = (state_q == SETUP) || (state_q == ACCESS);

  // Selects are decoded from state so an async reset drops them at once.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_psel
      assign psel_vec[gi] = apb_active && (sel_q == 2'(gi));
    end
  endgenerate

  assign PSEL0   = psel_vec[0];
  assign PSEL1   = psel_vec[1];
  assign PSEL2   = psel_vec[2];
  assign PSEL3   = psel_vec[3];
  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    ready    = 1'b0;
    busErr   = 1'b0;
    busRData = '0;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          paddr_d  = busAddr;
          pwdata_d = busWData;
          pwrite_d = busWe;
          sel_d    = busAddr[13:12];
          state_d  = addr_hit ? SETUP : ERROR;
        end
      end
      SETUP: begin
        cnt_d   = 8'd0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_vec[sel_q]) begin
          ready    = 1'b1;
          busRData = prdata_arr[sel_q];
          state_d  = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ERROR: begin
        ready    = 1'b1;
        busErr   = 1'b1;
        busRData = pwrite_q ? 32'd0 : ERR_RDATA;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Downstream stage of the RV32I core's data bus. Converts the core's single-transfer request interface (transfer/busWe/busAddr/busWData, answered by ready/busRData) into an APB3 master transaction. Decodes the address to one of four peripheral selects (RAM, GPIO, UART, spare). Bounds each access with a timeout so the core never stalls forever.

Parameters:
ADDR_BASE, 32'h1000_0000, base of the peripheral window; decode is valid only when busAddr[31:16] == ADDR_BASE[31:16].
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before a forced error completion (range 2..255).
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an unmapped or timed-out access.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
transfer  in  1  one-cycle request strobe from the core; busAddr/busWe/busWData are valid in the same cycle.
busWe  in  1  1 = write, 0 = read.
busAddr  in  32  byte address.
busWData  in  32  write data.
busRData  out  32  read data; valid while ready=1.
ready  out  1  one-cycle completion pulse to the core.
busErr  out  1  high together with ready when the access was unmapped or timed out.
PADDR  out  32  latched address.
PWRITE  out  1  latched busWe.
PWDATA  out  32  latched write data.
PENABLE  out  1  APB enable.
PSEL0..PSEL3  out  1 each  slave selects: RAM [15:12]=0, GPIO =1, UART =2, spare =3.
PRDATA0..PRDATA3  in  32 each  slave read data.
PREADY0..PREADY3  in  1 each  slave ready.

Behaviour:
- Reset (reset=0, async): state=IDLE; PADDR/PWDATA=0; PWRITE, PENABLE, PSEL0..3, ready, busErr=0; busRData=0; timeout counter=0.
- Decode: hit = busAddr[31:16]==ADDR_BASE[31:16] && busAddr[15:12]<=3; sel index = busAddr[13:12]. Any other address is unmapped.
- FSM states IDLE, SETUP, ACCESS, ERROR.
- IDLE:
  - transfer=1 latches addr, we, wdata and the decode result.
  - Mapped access goes to SETUP; unmapped goes to ERROR.
  - transfer in any state other than IDLE is ignored.
- SETUP: exactly one cycle. Selected PSELx=1, PENABLE=0. Always goes to ACCESS. Counter cleared.
- ACCESS: selected PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
  - Selected PREADYx=1 → ready=1 and busRData=PRDATAx in that same cycle (combinational). busErr=0. Next state IDLE.
  - Else counter increments. When the counter reaches TIMEOUT_CYCLES-1 without PREADY, go to ERROR; PSEL and PENABLE drop on the next edge.
  - Unselected slaves' PREADY/PRDATA are ignored.
- ERROR: one cycle. ready=1, busErr=1, busRData=ERR_RDATA for reads and 0 for writes. No PSEL asserted. Next state IDLE.
- Latency:
  - Zero-wait-state slave: transfer at cycle N, ready at cycle N+2.
  - Each wait state adds one cycle.
  - Unmapped access: ready at N+1.
- Back-to-back: a new transfer is accepted in the IDLE cycle immediately after ready, so the minimum issue interval is 3 cycles.
- Outside completion cycles: ready=0, busErr=0, busRData=0.
- Reset mid-transaction returns to IDLE immediately with all selects and enables low. The pending access is lost and no ready is issued.
- Only one PSEL is ever high at a time.

Test Plan:
1. Write 0x0000_00A5 to 0x1000_1004 (GPIO), PREADY1 tied high → PSEL1 high for 2 cycles, PENABLE in the 2nd, PWRITE=1, PWDATA=0xA5; ready at N+2 with busErr=0.
2. Read 0x1000_0010 (RAM), PREADY0 low for 3 ACCESS cycles, PRDATA0=0x1234_5678 → ready at N+5, busRData=0x1234_5678, PADDR stable throughout.
3. Read 0x2000_0000 (unmapped) → no PSEL asserted; ready=1, busErr=1, busRData=0xDEAD_BEEF at N+1.
4. Read 0x1000_2000 (UART) with PREADY2 stuck low, TIMEOUT_CYCLES=16 → PENABLE high for 16 cycles, then the ERROR cycle with ready=1, busErr=1, busRData=0xDEAD_BEEF.
5. Back-to-back: write to RAM, then a read from GPIO issued in the cycle right after ready; a second transfer pulse during SETUP is ignored → exactly two APB transactions, each with correct PSEL.
6. Assert reset=0 during ACCESS of a RAM write → all PSEL, PENABLE and ready go 0 asynchronously; after release the FSM is IDLE and a new transfer completes normally.
